// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// Decode-to-execute pipeline register and ALU operand issuer.
//  - Captures D-stage operands, register indices and control on each clk edge
//    (priority: rst_n low, then FlushE, then StallE, then load).
//  - Decodes ALUOpD/funct3D/funct7b5D/opb5D into the 3-bit ALU control code
//    and an illegal-operation flag, registered into ALUControlE/IllegalE.
//  - Resolves RAW hazards by forwarding from the M stage (ALUResultM) or the
//    W stage (ResultW) onto SrcAE and WriteDataE/SrcBE.
// Ports:
//  clk, rst_n (synchronous, active low), StallE, FlushE   : control
//  RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD, RegWriteD, ALUSrcD,
//  ALUOpD, funct3D, funct7b5D, opb5D                        : D-stage inputs
//  ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW     : forward sources
//  SrcAE, SrcBE, ALUControlE, WriteDataE, RdE, Rs1E, Rs2E,
//  RegWriteE, IllegalE, ForwardAE, ForwardBE                : E-stage outputs
module ex_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic [WIDTH-1:0]   RD1D,
  input  logic [WIDTH-1:0]   RD2D,
  input  logic [WIDTH-1:0]   ImmExtD,
  input  logic [REGBITS-1:0] Rs1D,
  input  logic [REGBITS-1:0] Rs2D,
  input  logic [REGBITS-1:0] RdD,
  input  logic               RegWriteD,
  input  logic               ALUSrcD,
  input  logic [1:0]         ALUOpD,
  input  logic [2:0]         funct3D,
  input  logic               funct7b5D,
  input  logic               opb5D,
  input  logic [WIDTH-1:0]   ALUResultM,
  input  logic [REGBITS-1:0] RdM,
  input  logic               RegWriteM,
  input  logic [WIDTH-1:0]   ResultW,
  input  logic [REGBITS-1:0] RdW,
  input  logic               RegWriteW,
  output logic [WIDTH-1:0]   SrcAE,
  output logic [WIDTH-1:0]   SrcBE,
  output logic [2:0]         ALUControlE,
  output logic [WIDTH-1:0]   WriteDataE,
  output logic [REGBITS-1:0] RdE,
  output logic [REGBITS-1:0] Rs1E,
  output logic [REGBITS-1:0] Rs2E,
  output logic               RegWriteE,
  output logic               IllegalE,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE
);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M-stage match wins over W-stage; x0 is hard-wired zero so never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REGBITS-1:0] rs,
    input logic [REGBITS-1:0] rd_m,
    input logic               rw_m,
    input logic [REGBITS-1:0] rd_w,
    input logic               rw_w
  );
    logic [1:0] sel;
    if (rw_m && (rd_m != {REGBITS{1'b0}}) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (rw_w && (rd_w != {REGBITS{1'b0}}) && (rd_w == rs)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  logic [WIDTH-1:0]   rd1_q, rd1_d;
  logic [WIDTH-1:0]   rd2_q, rd2_d;
  logic [WIDTH-1:0]   imm_q, imm_d;
  logic [REGBITS-1:0] rs1_q, rs1_d;
  logic [REGBITS-1:0] rs2_q, rs2_d;
  logic [REGBITS-1:0] rd_q, rd_d;
  logic               regwrite_q, regwrite_d;
  logic               alusrc_q, alusrc_d;
  logic [2:0]         aluctrl_q, aluctrl_d;
  logic               illegal_q, illegal_d;

  logic [2:0]         aluctrl_dec_s;
  logic               illegal_dec_s;

  // ALU control decode from D-stage opcode fields.
  always_comb begin
    aluctrl_dec_s = 3'd0;
    illegal_dec_s = 1'b0;
    case (ALUOpD)
      2'b00: aluctrl_dec_s = 3'd0;
      2'b01: aluctrl_dec_s = 3'd1;
      2'b10: begin
        case (funct3D)
          3'b000: aluctrl_dec_s = (funct7b5D && opb5D) ? 3'd1 : 3'd0;
          3'b111: aluctrl_dec_s = 3'd2;
          3'b110: aluctrl_dec_s = 3'd3;
          3'b100: aluctrl_dec_s = 3'd6;
          3'b010,
          3'b011: aluctrl_dec_s = 3'd5;
          // Shifts are not supported: code 7 makes the ALU return 0.
          3'b001,
          3'b101: begin
            aluctrl_dec_s = 3'd7;
            illegal_dec_s = 1'b1;
          end
          default: aluctrl_dec_s = 3'd0;
        endcase
      end
      default: aluctrl_dec_s = 3'd0;
    endcase
  end

  // Next-state for the E register: flush beats stall beats load.
  always_comb begin
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    alusrc_d   = alusrc_q;
    aluctrl_d  = aluctrl_q;
    illegal_d  = illegal_q;
    if (FlushE) begin
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      regwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      aluctrl_d  = 3'd0;
      illegal_d  = 1'b0;
    end else if (StallE) begin
      rd1_d      = rd1_q;
    end else begin
      rd1_d      = RD1D;
      rd2_d      = RD2D;
      imm_d      = ImmExtD;
      rs1_d      = Rs1D;
      rs2_d      = Rs2D;
      rd_d       = RdD;
      regwrite_d = RegWriteD;
      alusrc_d   = ALUSrcD;
      aluctrl_d  = aluctrl_dec_s;
      illegal_d  = illegal_dec_s;
    end
  end

  // E pipeline register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= 3'd0;
      illegal_q  <= 1'b0;
    end else begin
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      alusrc_q   <= alusrc_d;
      aluctrl_q  <= aluctrl_d;
      illegal_q  <= illegal_d;
    end
  end

  // Forward selects track the live M/W inputs even while E is stalled.
  always_comb begin
    ForwardAE = fwd_sel(rs1_q, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(rs2_q, RdM, RegWriteM, RdW, RegWriteW);
  end

  // Operand muxes; the unused select 11 falls back to the register value.
  always_comb begin
    case (ForwardAE)
      FWD_M:   SrcAE = ALUResultM;
      FWD_W:   SrcAE = ResultW;
      default: SrcAE = rd1_q;
    endcase
    case (ForwardBE)
      FWD_M:   WriteDataE = ALUResultM;
      FWD_W:   WriteDataE = ResultW;
      default: WriteDataE = rd2_q;
    endcase
    if (alusrc_q) begin
      SrcBE = imm_q;
    end else begin
      SrcBE = WriteDataE;
    end
  end

  assign ALUControlE = aluctrl_q;
  assign IllegalE    = illegal_q;
  assign RdE         = rd_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RegWriteE   = regwrite_q;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Decode-to-execute pipeline register and operand issuer that drives the execute-stage ALU inputs SrcAE, SrcBE and ALUControlE.
- Registers decode-stage operands and control, decodes the 3-bit ALU control code, and resolves data hazards with M/W forwarding.
- Honours stall and flush from the hazard unit.
- Sits between the register file/immediate extender (D stage) and the ALU (E stage).

Parameters:
- WIDTH, 32, datapath width of operands and results.
- REGBITS, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- StallE  in  1  hold the E register
- FlushE  in  1  replace the E register contents with a bubble
- RD1D  in  WIDTH  register file port 1 data
- RD2D  in  WIDTH  register file port 2 data
- ImmExtD  in  WIDTH  extended immediate
- Rs1D  in  REGBITS  source register 1 index
- Rs2D  in  REGBITS  source register 2 index
- RdD  in  REGBITS  destination register index
- RegWriteD  in  1  instruction writes the register file
- ALUSrcD  in  1  1 selects the immediate for operand B
- ALUOpD  in  2  ALU operation class
- funct3D  in  3  instruction funct3 field
- funct7b5D  in  1  funct7 bit 5
- opb5D  in  1  opcode bit 5 (R-type indicator)
- ALUResultM  in  WIDTH  memory-stage forward source
- RdM  in  REGBITS  memory-stage destination register
- RegWriteM  in  1  memory-stage write enable
- ResultW  in  WIDTH  writeback forward source
- RdW  in  REGBITS  writeback destination register
- RegWriteW  in  1  writeback write enable
- SrcAE  out  WIDTH  ALU operand A
- SrcBE  out  WIDTH  ALU operand B
- ALUControlE  out  3  ALU operation code
- WriteDataE  out  WIDTH  forwarded rs2 value, used for stores
- RdE  out  REGBITS  registered destination register
- Rs1E  out  REGBITS  registered source register 1
- Rs2E  out  REGBITS  registered source register 2
- RegWriteE  out  1  registered write enable
- IllegalE  out  1  unsupported ALU operation in E
- ForwardAE  out  2  forwarding select for operand A
- ForwardBE  out  2  forwarding select for operand B

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge): every E register clears to 0. This gives SrcAE=0, SrcBE=0, ALUControlE=0, RegWriteE=0 and IllegalE=0.
- Update priority at each clk edge: reset, then FlushE, then StallE, then load.
  - Flush loads a bubble: all data and indices 0, RegWriteE=0, ALUControlE=0 (add), IllegalE=0.
  - Stall holds every register.
  - Otherwise all D inputs are captured.
- Latency: D inputs appear on the E outputs 1 cycle later.
- ALU decode is combinational on D inputs and registered into ALUControlE/IllegalE:
  - ALUOp 00 → 0 (add).
  - ALUOp 01 → 1 (sub).
  - ALUOp 11 → 0 (add).
  - ALUOp 10 → decode funct3:
    - 000 → 1 if funct7b5 & opb5, else 0.
    - 111 → 2 (and).
    - 110 → 3 (or).
    - 100 → 6 (xor).
    - 010 or 011 → 5 (less-than, unsigned compare).
    - 001 or 101 → 7 with IllegalE=1; the ALU returns 0 for code 7.
  - Code 4 (greater-than) is not produced by this decoder.
- Forwarding is combinational on registered Rs1E/Rs2E and the live M/W inputs:
  - ForwardAE=10 when RegWriteM & RdM≠0 & RdM==Rs1E.
  - Otherwise ForwardAE=01 when RegWriteW & RdW≠0 & RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - M has priority over W. Register x0 is never forwarded.
  - ForwardBE is identical, using Rs2E.
- Operand muxes:
  - SrcAE = ALUResultM (10), ResultW (01), or the registered RD1 (00).
  - WriteDataE is the same selection applied to the registered RD2.
  - SrcBE = registered ImmExt when registered ALUSrc=1, else WriteDataE.
- Value 11 is never produced on ForwardAE/BE. If seen, the mux treats it as 00.
- Stall with changing M/W inputs: the registers hold, but the forwarded outputs track the current M/W values.
- Flush and stall asserted together: flush wins.
- Reset asserted mid-stall: reset wins.
- No arithmetic in this block. Widths pass through unchanged.

Test Plan:
- Reset: rst_n=0 for 2 cycles with nonzero D inputs → all outputs 0. After release, RD1D=5, RD2D=7, ALUOpD=10, funct3D=000, funct7b5D=0 → next cycle SrcAE=5, SrcBE=7, ALUControlE=0.
- Decode sweep, ALUOp=10:
  - funct3 000 with funct7b5=1, opb5=1 → 1.
  - 111 → 2.
  - 110 → 3.
  - 100 → 6.
  - 010 → 5.
  - 001 → 7 with IllegalE=1.
  - ALUOp=01 → 1.
  - ALUOp=00 with ALUSrcD=1, ImmExtD=0x10 → SrcBE=0x10.
- Forwarding: Rs1E=3, RdM=3, RegWriteM=1, ALUResultM=0xAA, RdW=3, RegWriteW=1, ResultW=0xBB → SrcAE=0xAA, ForwardAE=10. Drop RegWriteM → SrcAE=0xBB, ForwardAE=01. Set Rs1E=RdM=0 → ForwardAE=00.
- Store path: ALUSrcE=1, Rs2E=4, RdW=4, RegWriteW=1, ResultW=0x1234 → SrcBE=ImmExt, WriteDataE=0x1234.
- Stall/flush: StallE=1 for 3 cycles while D changes → E registers unchanged. StallE=1 and FlushE=1 together → bubble (RegWriteE=0, ALUControlE=0).
- Reset mid-stall: StallE=1 and rst_n=0 at the same edge → all registers cleared.
